alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Multi-cycle execute unit. It is the consumer side of the ALU op/source encodings that the decoder produces.
- Accepts one decoded ALU micro-op per valid/ready handshake and resolves operand sources (register, PC, zero, immediate, constant 4).
- Performs single-cycle arithmetic/logic, and iterative one-bit-per-cycle shifts.
- Returns the result through an output valid/ready handshake. Sits between decode/issue and writeback in the core.

Parameters:
- XLEN, 32, datapath width. Power of two, ≥8.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept.
- in_op  in  4  alu_op_e encoding.
- in_src_a  in  3  alu_src_e for operand A. Legal: REG, PC, ZERO.
- in_src_b  in  3  alu_src_e for operand B. Legal: REG, IMM, FOUR.
- in_rs1  in  XLEN  register operand A.
- in_rs2  in  XLEN  register operand B.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_illegal  out  1  op or source encoding was illegal.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_illegal=0, busy=0, shift counter=0.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE); no overlap between ops.
  - Output holds stable while out_valid && !out_ready; transfer completes on out_valid && out_ready.
- Operand A: REG→rs1, PC→pc, ZERO→0. Any other code→0 with illegal=1.
- Operand B: REG→rs2, IMM→imm, FOUR→4. Any other code (including ZERO, PC)→0 with illegal=1.
- Op semantics, all modulo 2^XLEN:
  - ADD, SUB: wrap-around.
  - AND, OR, XOR: bitwise.
  - SLT: signed compare → {0…,1} or 0.
  - SLTU: unsigned compare.
  - SLL, SRL, SRA: shift by B[SHW-1:0]; upper bits of B ignored.
  - Op codes 4'b1010–4'b1111: result 0, illegal=1.
- States IDLE, SHIFT, DONE:
  - IDLE: on accept of a non-shift op, or a shift with amount 0, compute the result and go to DONE. out_valid rises the cycle after the accept edge (latency 1).
  - IDLE: on accept of a shift with amount k>0, load the working register with A and counter=k, then go to SHIFT.
  - SHIFT: each cycle shift one bit (SRA replicates the MSB; SRL/SLL fill 0) and decrement the counter. On the edge where the counter reaches 0, go to DONE. out_valid rises k+1 cycles after the accept edge.
  - DONE: out_valid=1. On out_ready go to IDLE; in_ready is 1 the following cycle (no same-cycle re-accept).
- flush=1 at an edge: go to IDLE from any state and clear out_valid and out_illegal. flush has priority over accept and output transfer. out_result keeps its value (don't-care).
- out_illegal is valid only with out_valid and clears when leaving DONE.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.

Test Plan:
- ADD, A=REG rs1=0xFFFFFFFF, B=IMM imm=1 → out_valid 1 cycle after accept, result 0x00000000, illegal=0.
- SRA, rs1=0x80000000, rs2=0x00000024 (amount 4) → busy for 4 SHIFT cycles, out_valid 5 cycles after accept, result 0xF8000000.
- SLT, rs1=0xFFFFFFFF, rs2=1 → 1; SLTU same operands → 0. Then ADD with A=PC, B=FOUR, pc=0x100 → 0x104.
- Backpressure: out_ready held 0 for 6 cycles after a SUB result (0x5−0x7 → 0xFFFFFFFE) → result stable, in_ready=0, in_valid ignored; on out_ready=1 state returns to IDLE.
- in_op=4'b1100 or in_src_b=ALU_SRC_PC → result 0, illegal=1; the next legal op reports illegal=0.
- flush during SHIFT (SLL by 20, flush at cycle 3) → IDLE next edge, out_valid never rises. rst_n pulsed low mid-SHIFT → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_iter_exec.sv
// Multi-cycle ALU execute unit: single-cycle arithmetic/logic and one-bit-per-cycle shifts,
// with valid/ready handshakes on both sides. Encodings shared with the decoder live in the package.
package alu_iter_exec_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_SRC_REG  = 3'd0,
    ALU_SRC_PC   = 3'd1,
    ALU_SRC_ZERO = 3'd2,
    ALU_SRC_IMM  = 3'd3,
    ALU_SRC_FOUR = 3'd4
  } alu_src_e;
endpackage

module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [2:0]      in_src_a,
  input  logic [2:0]      in_src_b,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  localparam logic [1:0] SK_SLL = 2'd0, SK_SRL = 2'd1, SK_SRA = 2'd2;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [1:0]      kind_q, kind_d;
  logic            ill_q, ill_d;

  logic [XLEN-1:0] op_a, op_b, alu_res, step_res;
  logic            ill_a, ill_b, ill_op, is_shift;
  logic [1:0]      kind_in;
  logic [SHW-1:0]  shamt;

  always_comb begin
    op_a  = '0;
    ill_a = 1'b0;
    case (in_src_a)
      ALU_SRC_REG:  op_a = in_rs1;
      ALU_SRC_PC:   op_a = in_pc;
      ALU_SRC_ZERO: op_a = '0;
      default:      ill_a = 1'b1;
    endcase

    op_b  = '0;
    ill_b = 1'b0;
    case (in_src_b)
      ALU_SRC_REG:  op_b = in_rs2;
      ALU_SRC_IMM:  op_b = in_imm;
      ALU_SRC_FOUR: op_b = XLEN'(4);
      default:      ill_b = 1'b1;
    endcase
  end

  assign shamt = op_b[SHW-1:0];

  // Shifts never use a barrel shifter; a zero-amount shift simply returns A.
  always_comb begin
    alu_res  = '0;
    ill_op   = 1'b0;
    is_shift = 1'b0;
    kind_in  = SK_SLL;
    case (in_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_SLL:  begin is_shift = 1'b1; kind_in = SK_SLL; alu_res = op_a; end
      ALU_SRL:  begin is_shift = 1'b1; kind_in = SK_SRL; alu_res = op_a; end
      ALU_SRA:  begin is_shift = 1'b1; kind_in = SK_SRA; alu_res = op_a; end
      default:  ill_op = 1'b1;
    endcase
  end

  always_comb begin
    step_res = {res_q[XLEN-2:0], 1'b0};
    case (kind_q)
      SK_SRL:  step_res = {1'b0, res_q[XLEN-1:1]};
      SK_SRA:  step_res = {res_q[XLEN-1], res_q[XLEN-1:1]};
      default: step_res = {res_q[XLEN-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ill_d  = ill_a | ill_b | ill_op;
          kind_d = kind_in;
          res_d  = alu_res;
          if (is_shift && shamt != '0) begin
            cnt_d   = shamt;
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        res_d = step_res;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over both accept and output transfer.
    if (flush) begin
      state_d = S_IDLE;
      ill_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= SK_SLL;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_result  = res_q;
  assign out_illegal = ill_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: hand-computed results, latencies, backpressure, flush and async reset.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;

  localparam int XLEN = 32;

  logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
  logic [3:0]      in_op;
  logic [2:0]      in_src_a, in_src_b;
  logic [XLEN-1:0] in_rs1, in_rs2, in_pc, in_imm, out_result;

  int checks = 0;
  int errors = 0;

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    in_op = op; in_src_a = sa; in_src_b = sb;
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles after the accept edge (1 = visible right after that edge).
  task automatic wait_res(output int lat, output int bcyc);
    lat = 1;
    bcyc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [XLEN-1:0] rs1,
                        input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] exp_res,
                        input logic exp_ill, input int exp_lat, input int exp_busy);
    int lat, bcyc;
    issue(op, sa, sb, rs1, rs2, pc, imm);
    wait_res(lat, bcyc);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(out_result), 64'(exp_res));
    chk({tag, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_busy >= 0) chk({tag, "_shift_cycles"}, 64'(bcyc), 64'(exp_busy));
    take();
    chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    $display("op %s result=0x%08h illegal=%0b latency=%0d", tag, out_result, out_illegal, lat);
  endtask

  initial begin
    int lat, bcyc;
    logic [XLEN-1:0] held;
    logic seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src_a = '0; in_src_b = '0;
    in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_wrap", ALU_ADD, ALU_SRC_REG, ALU_SRC_IMM, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1,
           32'h0000_0000, 1'b0, 1, 0);
    run_op("sra4", ALU_SRA, ALU_SRC_REG, ALU_SRC_REG, 32'h8000_0000, 32'h0000_0024, 32'h0, 32'h0,
           32'hF800_0000, 1'b0, 5, 4);
    run_op("slt", ALU_SLT, ALU_SRC_REG, ALU_SRC_REG, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0,
           32'h1, 1'b0, 1, -1);
    run_op("sltu", ALU_SLTU, ALU_SRC_REG, ALU_SRC_REG, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0,
           32'h0, 1'b0, 1, -1);
    run_op("add_pc4", ALU_ADD, ALU_SRC_PC, ALU_SRC_FOUR, 32'h0, 32'h0, 32'h100, 32'h0,
           32'h104, 1'b0, 1, -1);
    run_op("srl1", ALU_SRL, ALU_SRC_REG, ALU_SRC_REG, 32'h8000_0000, 32'h0000_0021, 32'h0, 32'h0,
           32'h4000_0000, 1'b0, 2, 1);
    run_op("sll0", ALU_SLL, ALU_SRC_REG, ALU_SRC_IMM, 32'h0000_0003, 32'h0, 32'h0, 32'h0000_0040,
           32'h0000_0003, 1'b0, 1, 0);
    run_op("sll3", ALU_SLL, ALU_SRC_REG, ALU_SRC_IMM, 32'h8000_0011, 32'h0, 32'h0, 32'h3,
           32'h0000_0088, 1'b0, 4, 3);
    run_op("xor", ALU_XOR, ALU_SRC_REG, ALU_SRC_REG, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h0,
           32'hFF00_EDCB, 1'b0, 1, -1);
    run_op("or", ALU_OR, ALU_SRC_REG, ALU_SRC_REG, 32'hA000_0005, 32'h0500_0030, 32'h0, 32'h0,
           32'hA500_0035, 1'b0, 1, -1);

    // Backpressure on a SUB result.
    issue(ALU_SUB, ALU_SRC_REG, ALU_SRC_REG, 32'h5, 32'h7, 32'h0, 32'h0);
    wait_res(lat, bcyc);
    chk("sub_result", 64'(out_result), 64'h0000_0000_FFFF_FFFE);
    held = out_result;
    in_op = ALU_ADD; in_rs1 = 32'h1234; in_rs2 = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    take();
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_out_valid_clear", 64'(out_valid), 64'd0);
    $display("op sub_backpressure result=0x%08h held 6 cycles", held);

    run_op("ill_op", 4'b1100, ALU_SRC_REG, ALU_SRC_REG, 32'h1111, 32'h2222, 32'h0, 32'h0,
           32'h0, 1'b1, 1, -1);
    run_op("ill_srcb", ALU_ADD, ALU_SRC_ZERO, ALU_SRC_PC, 32'h1111, 32'h2222, 32'h300, 32'h0,
           32'h0, 1'b1, 1, -1);
    run_op("legal_after", ALU_AND, ALU_SRC_REG, ALU_SRC_REG, 32'hF0F0, 32'hFF00, 32'h0, 32'h0,
           32'hF000, 1'b0, 1, -1);

    // Flush during a 20-step SLL, raised in cycle 3 after accept.
    issue(ALU_SLL, ALU_SRC_REG, ALU_SRC_REG, 32'h1, 32'd20, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_illegal", 64'(out_illegal), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    $display("op sll_flush out_valid_seen=%0b", seen);

    // Async reset mid-shift, sampled before any further clock edge.
    issue(ALU_SRA, ALU_SRC_REG, ALU_SRC_REG, 32'h8000_0000, 32'd10, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(out_result), 64'd0);
    chk("arst_illegal", 64'(out_illegal), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    $display("op sra_async_reset busy=%0b result=0x%08h", busy, out_result);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("post_rst_add", ALU_ADD, ALU_SRC_REG, ALU_SRC_REG, 32'h2, 32'h3, 32'h0, 32'h0,
           32'h5, 1'b0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
